// File: rtl/wb_bus_arbiter_pkg.sv
// Shared encodings, widths and bus payload type for the two-master Wishbone arbiter.
// Tie-break policy is selected at build time by WB_ARB_ROUND_ROBIN_EN (see wb_bus_arbiter).
package wb_bus_arbiter_pkg;

   localparam int unsigned BUS_W = 32;
   localparam int unsigned SEL_W = 4;
   localparam int unsigned GNT_W = 2;

   localparam logic [BUS_W-1:0] ZERO_WORD  = '0;
   localparam logic             RST_ENABLE = 1'b1;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_GNT0 = 2'd1,
      ARB_GNT1 = 2'd2,
      ARB_ERR  = 2'd3
   } arb_state_t;

   localparam logic [GNT_W-1:0] GNT_NONE = 2'b00;
   localparam logic [GNT_W-1:0] GNT_M0   = 2'b01;
   localparam logic [GNT_W-1:0] GNT_M1   = 2'b10;

   // Master-to-slave request payload
   typedef struct packed {
      logic [BUS_W-1:0] addr;
      logic [BUS_W-1:0] data;
      logic             we;
      logic [SEL_W-1:0] sel;
      logic             stb;
      logic             cyc;
   } wb_req_t;

   // Grant-state that owns a given one-hot grant
   function automatic arb_state_t gnt_state(input logic [GNT_W-1:0] g);
      return (g == GNT_M1) ? ARB_GNT1 : ARB_GNT0;
   endfunction

   // The master that is not g
   function automatic logic [GNT_W-1:0] other_grant(input logic [GNT_W-1:0] g);
      return (g == GNT_M1) ? GNT_M0 : GNT_M1;
   endfunction

endpackage

// File: rtl/wb_bus_arbiter_timeout.sv
// Bus-hang watchdog: counts enabled cycles, flags expiry at TIMEOUT_CYCLES-1.
// TIMEOUT_CYCLES = 0 disables expiry; TIMEOUT_CYCLES must be < 2**CNT_W.
module wb_arb_timeout #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expire_c
);
   import wb_bus_arbiter_pkg::*;

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CNT_W'(1);
      end
   end

   // Expiry only while still stuck; an ack in the same cycle drops enable and wins
   assign expire_c = (TIMEOUT_CYCLES != 0) && enable &&
                     (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wb_bus_arbiter.sv
// Two-master (M0 data, M1 instruction) to one-slave Wishbone arbiter with hang timeout.
// Define WB_ARB_ROUND_ROBIN_EN for round-robin tie-break; default is fixed M0 priority.
module wb_bus_arbiter
   import wb_bus_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [BUS_W-1:0] m0_addr_i,
   input  logic [BUS_W-1:0] m0_data_i,
   input  logic             m0_we_i,
   input  logic [SEL_W-1:0] m0_sel_i,
   input  logic             m0_stb_i,
   input  logic             m0_cyc_i,
   output logic [BUS_W-1:0] m0_data_o,
   output logic             m0_ack_o,
   output logic             m0_err_o,
   input  logic [BUS_W-1:0] m1_addr_i,
   input  logic [BUS_W-1:0] m1_data_i,
   input  logic             m1_we_i,
   input  logic [SEL_W-1:0] m1_sel_i,
   input  logic             m1_stb_i,
   input  logic             m1_cyc_i,
   output logic [BUS_W-1:0] m1_data_o,
   output logic             m1_ack_o,
   output logic             m1_err_o,
   output logic [BUS_W-1:0] s_addr_o,
   output logic [BUS_W-1:0] s_data_o,
   output logic             s_we_o,
   output logic [SEL_W-1:0] s_sel_o,
   output logic             s_stb_o,
   output logic             s_cyc_o,
   input  logic [BUS_W-1:0] s_data_i,
   input  logic             s_ack_i,
   output logic [GNT_W-1:0] grant_o
);

   arb_state_t       state;
   logic [GNT_W-1:0] grant;
   logic [GNT_W-1:0] tie_pick;
   logic             arb_go;
   logic [GNT_W-1:0] arb_gnt;
   logic             busy;
   logic             drop;
   logic             tmo_clear;
   logic             tmo_enable;
   logic             expire;
   wb_req_t          m0_req;
   wb_req_t          m1_req;
   wb_req_t          s_req;

   assign m0_req = '{addr: m0_addr_i, data: m0_data_i, we: m0_we_i,
                     sel: m0_sel_i, stb: m0_stb_i, cyc: m0_cyc_i};
   assign m1_req = '{addr: m1_addr_i, data: m1_data_i, we: m1_we_i,
                     sel: m1_sel_i, stb: m1_stb_i, cyc: m1_cyc_i};

`ifdef WB_ARB_ROUND_ROBIN_EN
   logic [GNT_W-1:0] last_grant;

   // Remembers the most recent grant so a tie favours the other master
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         last_grant <= GNT_M1;
      end else if (arb_go) begin
         last_grant <= arb_gnt;
      end
   end

   assign tie_pick = other_grant(last_grant);
`else
   assign tie_pick = GNT_M0;
`endif

   assign busy = (state == ARB_GNT0) || (state == ARB_GNT1);
   assign drop = ((state == ARB_GNT0) && !m0_cyc_i) ||
                 ((state == ARB_GNT1) && !m1_cyc_i);

   // New-grant decision: from idle, or direct handoff when the owner releases
   always_comb begin
      arb_go  = 1'b0;
      arb_gnt = GNT_NONE;
      case (state)
         ARB_IDLE: begin
            arb_go = m0_cyc_i | m1_cyc_i;
            if (m0_cyc_i && m1_cyc_i) begin
               arb_gnt = tie_pick;
            end else if (m0_cyc_i) begin
               arb_gnt = GNT_M0;
            end else if (m1_cyc_i) begin
               arb_gnt = GNT_M1;
            end
         end
         ARB_GNT0: begin
            arb_go  = !m0_cyc_i && m1_cyc_i;
            arb_gnt = GNT_M1;
         end
         ARB_GNT1: begin
            arb_go  = !m1_cyc_i && m0_cyc_i;
            arb_gnt = GNT_M0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         state <= ARB_IDLE;
         grant <= GNT_NONE;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (arb_go) begin
                  state <= gnt_state(arb_gnt);
                  grant <= arb_gnt;
               end
            end
            ARB_GNT0, ARB_GNT1: begin
               if (drop) begin
                  if (arb_go) begin
                     state <= gnt_state(arb_gnt);
                     grant <= arb_gnt;
                  end else begin
                     state <= ARB_IDLE;
                     grant <= GNT_NONE;
                  end
               end else if (expire) begin
                  state <= ARB_ERR;
               end
            end
            default: begin
               state <= ARB_IDLE;
               grant <= GNT_NONE;
            end
         endcase
      end
   end

   // Request/response steering; only the granted master sees slave traffic
   always_comb begin
      s_req     = '0;
      m0_data_o = ZERO_WORD;
      m0_ack_o  = 1'b0;
      m0_err_o  = 1'b0;
      m1_data_o = ZERO_WORD;
      m1_ack_o  = 1'b0;
      m1_err_o  = 1'b0;
      case (state)
         ARB_GNT0: begin
            s_req     = m0_req;
            m0_data_o = s_data_i;
            m0_ack_o  = s_ack_i;
         end
         ARB_GNT1: begin
            s_req     = m1_req;
            m1_data_o = s_data_i;
            m1_ack_o  = s_ack_i;
         end
         ARB_ERR: begin
            m0_err_o = (grant == GNT_M0);
            m1_err_o = (grant == GNT_M1);
         end
         default: ;
      endcase
   end

   assign s_addr_o = s_req.addr;
   assign s_data_o = s_req.data;
   assign s_we_o   = s_req.we;
   assign s_sel_o  = s_req.sel;
   assign s_stb_o  = s_req.stb;
   assign s_cyc_o  = s_req.cyc;
   assign grant_o  = grant;

   assign tmo_enable = busy && s_stb_o && !s_ack_i;
   assign tmo_clear  = !busy || s_ack_i || drop || expire;

   wb_arb_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_W          (CNT_W)
   ) u_timeout (
      .clk      (clk),
      .rst      (rst),
      .clear    (tmo_clear),
      .enable   (tmo_enable),
      .expire_c (expire)
   );

endmodule
